// File: rtl/assoc_cache_core.sv
// Two-way set-associative tag store with per-set LRU replacement and hit/reference counters.
// Holds tags, valid bits and LRU state only; no data storage.
module assoc_cache_core #(
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned INDEX_BITS  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_in,
    input  logic        state,
    output logic        hit,
    output logic [31:0] ref_count,
    output logic [31:0] hit_count
);

    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned SETS     = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0]   tag0_q [SETS];
    logic [TAG_BITS-1:0]   tag1_q [SETS];
    logic [SETS-1:0]       valid0_q;
    logic [SETS-1:0]       valid1_q;
    logic [SETS-1:0]       lru_q;

    logic [INDEX_BITS-1:0] set_idx;
    logic [TAG_BITS-1:0]   ref_tag;
    logic                  unused_offset;
    logic                  lookup_en;
    logic                  hit0;
    logic                  hit1;
    logic                  any_hit;
    logic                  victim;
    logic                  touched_way;

    assign set_idx       = addr_in[OFFSET_BITS +: INDEX_BITS];
    assign ref_tag       = addr_in[31 -: TAG_BITS];
    assign unused_offset = ^addr_in[OFFSET_BITS-1:0];
    assign lookup_en     = rst_n && !state;

    always_comb begin
        hit0    = valid0_q[set_idx] && (tag0_q[set_idx] == ref_tag);
        hit1    = valid1_q[set_idx] && (tag1_q[set_idx] == ref_tag);
        any_hit = hit0 || hit1;

        // Fill an empty way before evicting; way 0 takes priority when both are empty.
        if (!valid0_q[set_idx]) begin
            victim = 1'b0;
        end else if (!valid1_q[set_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[set_idx];
        end

        touched_way = any_hit ? hit1 : victim;
    end

    // Control state and statistics; reset clears everything that affects lookup results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid0_q  <= '0;
            valid1_q  <= '0;
            lru_q     <= '0;
            hit       <= 1'b0;
            ref_count <= '0;
            hit_count <= '0;
        end else if (!state) begin
            hit                <= any_hit;
            lru_q[set_idx]     <= ~touched_way;
            ref_count          <= ref_count + 32'd1;
            if (any_hit) begin
                hit_count <= hit_count + 32'd1;
            end else if (victim) begin
                valid1_q[set_idx] <= 1'b1;
            end else begin
                valid0_q[set_idx] <= 1'b1;
            end
        end
    end

    // Tags need no reset: they are only consulted behind their valid bit.
    always_ff @(posedge clk) begin
        if (lookup_en && !any_hit) begin
            if (victim) begin
                tag1_q[set_idx] <= ref_tag;
            end else begin
                tag0_q[set_idx] <= ref_tag;
            end
        end
    end

endmodule
